// File: rtl/risc8_pin_debounce.sv
// risc8_pin_debounce: eight independent pin debouncers feeding the SoC pin_b
// input. Each bit is synchronized through two flops, then must hold a new
// level for DEBOUNCE_CYCLES consecutive clocks before pin_b takes it.
// Optional macro RISC8_PIN_EDGE_EN adds sticky rise/fall pending flags with
// write-1-to-clear and an OR-reduced irq; without it those outputs are 0.

// One debounced bit: synchronizer, saturating counter, accepted level.
module risc8_pin_debounce_bit #(
  parameter int N  = 6000,
  parameter int CW = 13
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic b_o,
  output logic rise_set_o,
  output logic fall_set_o
);
  localparam logic [CW-1:0] CNT_MAX = CW'(N - 1);

  logic          sync1_q, sync2_q, b_q, b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;

  // Two-flop synchronizer; nothing downstream sees raw_i directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  assign accept = (sync2_q != b_q) && (cnt_q == CNT_MAX);

  // Count while the synchronized level disagrees; any agreement is a glitch
  // and restarts the count. Terminal count loads the new level instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    b_d   = b_q;
    if (sync2_q == b_q) begin
      cnt_d = '0;
    end else if (accept) begin
      b_d   = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter and accepted level registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      b_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      b_q   <= b_d;
    end
  end

  assign b_o        = b_q;
  assign rise_set_o = accept &  sync2_q;
  assign fall_set_o = accept & ~sync2_q;
endmodule

module risc8_pin_debounce #(
  parameter int DEBOUNCE_CYCLES = 6000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pin_raw,
  output logic [7:0] pin_b,
  output logic [7:0] rise_pending,
  output logic [7:0] fall_pending,
  input  logic [7:0] clear,
  output logic       irq
);
  // Counter just wide enough for N-1, never narrower than one bit.
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [7:0] rise_set, fall_set;

  for (genvar i = 0; i < 8; i++) begin : g_bit
    risc8_pin_debounce_bit #(.N(DEBOUNCE_CYCLES), .CW(CW)) u_bit (
      .clk        (clk),
      .reset      (reset),
      .raw_i      (pin_raw[i]),
      .b_o        (pin_b[i]),
      .rise_set_o (rise_set[i]),
      .fall_set_o (fall_set[i])
    );
  end

`ifdef RISC8_PIN_EDGE_EN
  logic [7:0] rise_q, rise_d, fall_q, fall_d;

  // A set on the same edge as a clear wins, so no edge is ever lost.
  always_comb begin
    rise_d = rise_set | (rise_q & ~clear);
    fall_d = fall_set | (fall_q & ~clear);
  end

  // Sticky pending flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise_pending = rise_q;
  assign fall_pending = fall_q;
  assign irq          = |{rise_q, fall_q};
`else
  // Edge reporting absent: flags and irq are constant, clear is ignored.
  logic unused_edge;
  assign unused_edge  = ^{clear, rise_set, fall_set};
  assign rise_pending = '0;
  assign fall_pending = '0;
  assign irq          = 1'b0;
`endif
endmodule

// File: tb/tb_risc8_pin_debounce.sv
// Bench for risc8_pin_debounce with N=4: per-edge vector table with a
// scoreboard queue, plus hand sequences for async reset and post-reset latency.
module tb_risc8_pin_debounce;
  localparam int N = 4;
`ifdef RISC8_PIN_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pin_raw, clear, pin_b, rise_pending, fall_pending;
  logic       irq;

  always #5 clk = ~clk;

  risc8_pin_debounce #(.DEBOUNCE_CYCLES(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .pin_raw      (pin_raw),
    .pin_b        (pin_b),
    .rise_pending (rise_pending),
    .fall_pending (fall_pending),
    .clear        (clear),
    .irq          (irq)
  );

  typedef struct packed {
    logic       rst;
    logic [7:0] raw, clr, b, r, f;
  } vec_t;
  typedef struct packed {
    logic [7:0] b, r, f;
    logic       irq;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  task automatic add(input logic rst, input logic [7:0] raw, clr, b, r, f, input int rep);
    vec_t v;
    v.rst = rst; v.raw = raw; v.clr = clr; v.b = b; v.r = r; v.f = f;
    for (int i = 0; i < rep; i++) tbl.push_back(v);
  endtask

  function automatic exp_t mk(input logic [7:0] b, r, f);
    exp_t e;
    e.b   = b;
    e.r   = EDGE_EN ? r : 8'h00;
    e.f   = EDGE_EN ? f : 8'h00;
    e.irq = |(e.r | e.f);
    return e;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, " pin_b"}, pin_b, e.b);
    chk({tag, " rise"}, rise_pending, e.r);
    chk({tag, " fall"}, fall_pending, e.f);
    chk({tag, " irq"}, {7'd0, irq}, {7'd0, e.irq});
  endtask

  initial begin
    exp_t e;
    reset = 1'b1; pin_raw = 8'h00; clear = 8'h00;

    //   rst raw    clr    pin_b  rise   fall   edges
    // reset state
    add(1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2);
    // single rising bit, accepted after edge N+1
    add(0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 5);
    add(0, 8'h01, 8'h00, 8'h01, 8'h01, 8'h00, 2);
    add(0, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 1);
    // 3-clock pulse: one short of acceptance, must be rejected
    add(0, 8'h09, 8'h00, 8'h01, 8'h00, 8'h00, 3);
    add(0, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 6);
    // 4-clock pulse: accepted high, then accepted low again
    add(0, 8'h09, 8'h00, 8'h01, 8'h00, 8'h00, 4);
    add(0, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 1);
    add(0, 8'h01, 8'h00, 8'h09, 8'h08, 8'h00, 4);
    add(0, 8'h01, 8'h00, 8'h01, 8'h08, 8'h08, 1);
    add(0, 8'h01, 8'h08, 8'h01, 8'h00, 8'h00, 1);
    // all bits high, then all fall; partial clear leaves irq up
    add(0, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h00, 5);
    add(0, 8'hFF, 8'h00, 8'hFF, 8'hFE, 8'h00, 1);
    add(0, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 1);
    add(0, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 5);
    add(0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 1);
    add(0, 8'h00, 8'h0F, 8'h00, 8'h00, 8'hF0, 1);
    add(0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF0, 1);
    add(0, 8'h00, 8'hF0, 8'h00, 8'h00, 8'h00, 1);
    // clear on the same edge as a rise: set wins
    add(0, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 5);
    add(0, 8'h04, 8'h04, 8'h04, 8'h04, 8'h00, 1);
    add(0, 8'h04, 8'h00, 8'h04, 8'h04, 8'h00, 1);
    add(0, 8'h04, 8'h04, 8'h04, 8'h00, 8'h00, 1);
    // reset mid-debounce discards the count; restart takes N+2 edges
    add(0, 8'h80, 8'h00, 8'h04, 8'h00, 8'h00, 3);
    add(1, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 1);
    add(0, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 5);
    add(0, 8'h80, 8'h00, 8'h80, 8'h80, 8'h00, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      reset = tbl[i].rst; pin_raw = tbl[i].raw; clear = tbl[i].clr;
      sb.push_back(mk(tbl[i].b, tbl[i].r, tbl[i].f));
      @(posedge clk); #1;
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL v%0d scoreboard: got empty expected entry", i);
      end else begin
        e = sb.pop_front();
        chk_all($sformatf("v%0d", i), e);
      end
    end

    // Asynchronous reset between edges clears everything without a clock.
    @(negedge clk);
    pin_raw = 8'hFF; clear = 8'h00;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk_all("async_rst", mk(8'h00, 8'h00, 8'h00));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    // pin_raw held high: pin_b must rise exactly on edge N+2 after release.
    for (int k = 1; k <= N + 2; k++) begin
      @(posedge clk); #1;
      e = mk((k == N + 2) ? 8'hFF : 8'h00, (k == N + 2) ? 8'hFF : 8'h00, 8'h00);
      chk_all($sformatf("post_rst_e%0d", k), e);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
